// File: rtl/round_robin_arbiter_3_pkg.sv
// Shared definitions for the three-way round-robin arbiter: state encoding,
// priority-pointer reset value and default address width.
package round_robin_arbiter_3_pkg;

    localparam int ARB_WIDTH = 8;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_BUSY    = 2'd1,
        ARB_RELEASE = 2'd2
    } arb_state_t;

    // Pointing at requester 3 makes requester 1 the first choice after reset.
    localparam logic [2:0] ARB_LAST_RESET = 3'b100;

endpackage

// File: rtl/rr_next_winner_3.sv
// Combinational round-robin pick for three requesters: first asserted request
// bit scanning circularly from the position after the one-hot last grant.
module rr_next_winner_3 (
    input  logic [2:0] iRequest,
    input  logic [2:0] LastGrant,
    output logic [2:0] oWinner
);

    always_comb begin
        oWinner = 3'b000;
        case (LastGrant)
            3'b001: begin
                if      (iRequest[1]) oWinner = 3'b010;
                else if (iRequest[2]) oWinner = 3'b100;
                else if (iRequest[0]) oWinner = 3'b001;
            end
            3'b010: begin
                if      (iRequest[2]) oWinner = 3'b100;
                else if (iRequest[0]) oWinner = 3'b001;
                else if (iRequest[1]) oWinner = 3'b010;
            end
            // 3'b100 and any corrupted pointer fall back to requester 1 first
            default: begin
                if      (iRequest[0]) oWinner = 3'b001;
                else if (iRequest[1]) oWinner = 3'b010;
                else if (iRequest[2]) oWinner = 3'b100;
            end
        endcase
    end

endmodule

// File: rtl/round_robin_arbiter_3.sv
// Three-way round-robin arbiter: registered one-hot grant and latched address,
// held until iDone, request withdrawal or watchdog expiry, then one RELEASE cycle.
module round_robin_arbiter_3
    import round_robin_arbiter_3_pkg::*;
#(
    parameter int SIZE         = ARB_WIDTH,
    parameter int TIMEOUT_BITS = 8
) (
    input  logic            Clock,
    input  logic            Reset,
    input  logic [2:0]      iRequest,
    input  logic [SIZE-1:0] iAddress1,
    input  logic [SIZE-1:0] iAddress2,
    input  logic [SIZE-1:0] iAddress3,
    input  logic            iDone,
    output logic [2:0]      oGrant,
    output logic [SIZE-1:0] oAddress,
    output logic            oValid,
    output logic            oTimeout
);

    localparam logic [TIMEOUT_BITS-1:0] WD_ONE  = TIMEOUT_BITS'(1);
    // Value held just before the counter reaches all-ones on the next edge.
    localparam logic [TIMEOUT_BITS-1:0] WD_LAST = ~WD_ONE;

    arb_state_t              state, state_nxt;
    logic [2:0]              last_grant, last_nxt;
    logic [TIMEOUT_BITS-1:0] wd, wd_nxt;
    logic [2:0]              grant_nxt;
    logic [SIZE-1:0]         addr_nxt;
    logic                    valid_nxt, timeout_nxt;
    logic [2:0]              winner;
    logic                    abandon, wd_full;

    rr_next_winner_3 u_next_winner (
        .iRequest  (iRequest),
        .LastGrant (last_grant),
        .oWinner   (winner)
    );

    assign abandon = ~|(iRequest & oGrant);
    assign wd_full = (wd == WD_LAST);

    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state      <= ARB_IDLE;
            last_grant <= ARB_LAST_RESET;
            wd         <= '0;
            oGrant     <= 3'b000;
            oAddress   <= '0;
            oValid     <= 1'b0;
            oTimeout   <= 1'b0;
        end else begin
            state      <= state_nxt;
            last_grant <= last_nxt;
            wd         <= wd_nxt;
            oGrant     <= grant_nxt;
            oAddress   <= addr_nxt;
            oValid     <= valid_nxt;
            oTimeout   <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        last_nxt    = last_grant;
        wd_nxt      = wd;
        grant_nxt   = oGrant;
        addr_nxt    = oAddress;
        valid_nxt   = 1'b0;
        timeout_nxt = 1'b0;
        case (state)
            ARB_IDLE: begin
                grant_nxt = 3'b000;
                if (|winner) begin
                    grant_nxt = winner;
                    wd_nxt    = '0;
                    valid_nxt = 1'b1;
                    state_nxt = ARB_BUSY;
                    case (winner)
                        3'b001:  addr_nxt = iAddress1;
                        3'b010:  addr_nxt = iAddress2;
                        default: addr_nxt = iAddress3;
                    endcase
                end
            end
            ARB_BUSY: begin
                wd_nxt = wd + WD_ONE;
                if (iDone || abandon || wd_full) begin
                    // Pointer moves as the grant drops, ready for the next IDLE pick.
                    last_nxt    = oGrant;
                    grant_nxt   = 3'b000;
                    timeout_nxt = wd_full && !iDone;
                    state_nxt   = ARB_RELEASE;
                end
            end
            ARB_RELEASE: begin
                grant_nxt = 3'b000;
                state_nxt = ARB_IDLE;
            end
            default: begin
                grant_nxt = 3'b000;
                state_nxt = ARB_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_round_robin_arbiter_3.sv
// Scoreboard bench for round_robin_arbiter_3 with TIMEOUT_BITS=3: directed
// stimulus pushes expected grants/timeouts, a negedge monitor pops and compares.
module tb_round_robin_arbiter_3;

    typedef struct packed {
        logic [2:0] g;
        logic [7:0] a;
    } exp_t;

    logic       Clock = 1'b0;
    logic       Reset = 1'b1;
    logic [2:0] iRequest = 3'b000;
    logic [7:0] iAddress1 = 8'h10;
    logic [7:0] iAddress2 = 8'h20;
    logic [7:0] iAddress3 = 8'h30;
    logic       iDone = 1'b0;
    logic [2:0] oGrant;
    logic [7:0] oAddress;
    logic       oValid;
    logic       oTimeout;

    int   n_cmp = 0;
    int   n_bad = 0;
    int   cyc = 0;
    int   grant_cyc = 0;
    logic prev_valid = 1'b0;
    exp_t exp_q[$];
    int   to_q[$];

    round_robin_arbiter_3 #(.SIZE(8), .TIMEOUT_BITS(3)) dut (
        .Clock     (Clock),
        .Reset     (Reset),
        .iRequest  (iRequest),
        .iAddress1 (iAddress1),
        .iAddress2 (iAddress2),
        .iAddress3 (iAddress3),
        .iDone     (iDone),
        .oGrant    (oGrant),
        .oAddress  (oAddress),
        .oValid    (oValid),
        .oTimeout  (oTimeout)
    );

    always #5 Clock = ~Clock;
    always @(posedge Clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // Monitor: every oValid strobe and every oTimeout pulse is matched against the queues.
    always @(negedge Clock) begin
        if (oValid) begin
            if (prev_valid) begin
                n_cmp++; n_bad++;
                $display("FAIL valid_width: oValid high two cycles, expected one");
            end
            if (exp_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_grant: got grant %b addr %0h, expected none", oGrant, oAddress);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                check("grant_addr", {21'd0, oGrant, oAddress}, {21'd0, e.g, e.a});
            end
            grant_cyc = cyc;
        end
        if (oTimeout) begin
            if (to_q.size() == 0) begin
                n_cmp++; n_bad++;
                $display("FAIL unexpected_timeout: got timeout at cycle %0d, expected none", cyc);
            end else begin
                check("timeout_delay", cyc - grant_cyc, to_q.pop_front());
                check("timeout_grant_low", {29'd0, oGrant}, 32'd0);
            end
        end
        prev_valid = oValid;
    end

    task automatic wait_grant(input string name);
        for (int i = 0; i < 20; i++) begin
            @(posedge Clock); #1;
            if (oValid) return;
        end
        n_cmp++; n_bad++;
        $display("FAIL %s: no grant within 20 cycles, expected one", name);
    endtask

    task automatic pulse_done();
        iDone = 1'b1;
        @(posedge Clock); #1;
        iDone = 1'b0;
    endtask

    initial begin
        #50000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "bench time limit");
    end

    initial begin
        #1;
        check("rst_grant",   {29'd0, oGrant}, 32'd0);
        check("rst_addr",    {24'd0, oAddress}, 32'd0);
        check("rst_valid",   {31'd0, oValid}, 32'd0);
        check("rst_timeout", {31'd0, oTimeout}, 32'd0);
        #11;
        Reset = 1'b0;

        // All three requesting: strict rotation with address capture.
        exp_q.push_back('{3'b001, 8'h10});
        exp_q.push_back('{3'b010, 8'h20});
        exp_q.push_back('{3'b100, 8'h30});
        exp_q.push_back('{3'b001, 8'h10});
        iRequest = 3'b111;
        for (int i = 0; i < 4; i++) begin
            wait_grant("rotation");
            repeat (2) begin @(posedge Clock); #1; end
            if (i == 3) iRequest = 3'b000;
            pulse_done();
        end
        repeat (2) begin @(posedge Clock); #1; end

        // Lone requester 2: regranted after RELEASE + IDLE.
        exp_q.push_back('{3'b010, 8'h20});
        exp_q.push_back('{3'b010, 8'h20});
        iRequest = 3'b010;
        wait_grant("lone_first");
        pulse_done();
        check("lone_release", {29'd0, oGrant}, 32'd0);
        @(posedge Clock); #1;
        check("lone_idle", {29'd0, oGrant}, 32'd0);
        @(posedge Clock); #1;
        check("lone_regrant", {29'd0, oGrant}, 32'd2);
        iRequest = 3'b000;
        repeat (3) begin @(posedge Clock); #1; end

        // Watchdog expiry on requester 3, then requester 1 is served.
        exp_q.push_back('{3'b100, 8'h30});
        to_q.push_back(7);
        exp_q.push_back('{3'b001, 8'h10});
        iRequest = 3'b111;
        wait_grant("timeout_grant");
        wait_grant("after_timeout");

        // iDone on the cycle the watchdog would expire: done wins.
        repeat (6) begin @(posedge Clock); #1; end
        check("held_before_wd", {29'd0, oGrant}, 32'd1);
        exp_q.push_back('{3'b010, 8'h20});
        pulse_done();
        check("done_wins_timeout", {31'd0, oTimeout}, 32'd0);
        check("done_wins_grant", {29'd0, oGrant}, 32'd0);
        wait_grant("after_done_wd");
        iAddress2 = 8'h99;
        pulse_done();

        // Requester 3 withdraws mid-BUSY; pointer must become 100.
        exp_q.push_back('{3'b100, 8'h30});
        wait_grant("drop_grant");
        repeat (2) begin @(posedge Clock); #1; end
        iRequest = 3'b011;
        @(posedge Clock); #1;
        check("drop_release", {29'd0, oGrant}, 32'd0);
        iRequest = 3'b111;
        exp_q.push_back('{3'b001, 8'h10});
        wait_grant("after_drop");

        // Asynchronous reset between edges mid-BUSY.
        @(posedge Clock); #3;
        Reset = 1'b1;
        #1;
        check("arst_grant",   {29'd0, oGrant}, 32'd0);
        check("arst_addr",    {24'd0, oAddress}, 32'd0);
        check("arst_valid",   {31'd0, oValid}, 32'd0);
        check("arst_timeout", {31'd0, oTimeout}, 32'd0);
        #10;
        Reset = 1'b0;
        exp_q.push_back('{3'b001, 8'h10});
        wait_grant("after_reset");
        iRequest = 3'b000;
        pulse_done();
        repeat (3) begin @(posedge Clock); #1; end

        check("grant_queue_empty", exp_q.size(), 0);
        check("timeout_queue_empty", to_q.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
